// File: rtl/lightsout_pkg.sv
// Shared definitions for the Lights Out grid engine: command encodings, FSM states
// and the scramble LFSR.
package lightsout_pkg;

    typedef enum logic [1:0] {
        OP_PRESS    = 2'd0,
        OP_SCRAMBLE = 2'd1,
        OP_CLEAR    = 2'd2,
        OP_RESERVED = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StScramble = 2'd1,
        StWon      = 2'd2
    } state_e;

    localparam logic [15:0] LFSR_RESET = 16'hACE1;
    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS  = 16'hB400;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/lightsout_if.sv
// Command and board-status bundle between the pin wrapper (master) and the game core (slave).
interface lightsout_if #(
    parameter int ROWS   = 5,
    parameter int COLS   = 5,
    parameter int MOVE_W = 10
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int N  = ROWS * COLS;

    logic              ena;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [RW-1:0]     cmd_row;
    logic [CW-1:0]     cmd_col;
    logic [15:0]       seed;
    logic [N-1:0]      board;
    logic [MOVE_W-1:0] move_count;
    logic              busy;
    logic              solved;
    logic              err;

    modport master (
        output ena, cmd_valid, cmd_op, cmd_row, cmd_col, seed,
        input  cmd_ready, board, move_count, busy, solved, err
    );

    modport slave (
        input  ena, cmd_valid, cmd_op, cmd_row, cmd_col, seed,
        output cmd_ready, board, move_count, busy, solved, err
    );

endinterface

// File: rtl/lightsout_press_mask.sv
// Plus-shaped toggle mask for one press; all-zero mask and o_valid=0 for off-grid coordinates.
module lightsout_press_mask #(
    parameter int  ROWS  = 5,
    parameter int  COLS  = 5,
    parameter int  TORUS = 0,
    localparam int RW    = $clog2(ROWS),
    localparam int CW    = $clog2(COLS),
    localparam int N     = ROWS * COLS
) (
    input  logic [RW-1:0] i_row,
    input  logic [CW-1:0] i_col,
    output logic          o_valid,
    output logic [N-1:0]  o_mask
);

    int w_r;
    int w_c;

    // Neighbour test along one axis; in torus mode the two ends are adjacent. Bits are set
    // rather than toggled, so a 2-wide torus still flips the shared neighbour only once.
    function automatic logic is_adj(input int a, input int b, input int len);
        return (a == b - 1) || (a == b + 1) ||
               ((TORUS != 0) && (((b == 0) && (a == len - 1)) || ((b == len - 1) && (a == 0))));
    endfunction

    always_comb begin
        w_r     = int'(i_row);
        w_c     = int'(i_col);
        o_valid = (w_r < ROWS) && (w_c < COLS);
        o_mask  = '0;
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                o_mask[i*COLS+j] = o_valid &&
                    (((i == w_r) && (j == w_c)) ||
                     ((j == w_c) && is_adj(i, w_r, ROWS)) ||
                     ((i == w_r) && is_adj(j, w_c, COLS)));
            end
        end
    end

endmodule

// File: rtl/lightsout_grid_core.sv
// Lights Out game engine: player presses, LFSR scramble, saturating move counter and win
// detect. All status outputs come straight from registers.
module lightsout_grid_core
    import lightsout_pkg::*;
#(
    parameter int ROWS     = 5,
    parameter int COLS     = 5,
    parameter int TORUS    = 0,
    parameter int SCRAMBLE = 20,
    parameter int MOVE_W   = 10
) (
    input  logic       clk,
    input  logic       rst,
    lightsout_if.slave lo
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int N  = ROWS * COLS;
    localparam int SW = $clog2(SCRAMBLE + 2);

    state_e            r_state, w_state_d;
    logic [N-1:0]      r_board, w_board_d;
    logic [MOVE_W-1:0] r_moves, w_moves_d;
    logic [15:0]       r_lfsr, w_lfsr_d;
    logic [SW-1:0]     r_scr_cnt, w_scr_cnt_d;
    logic              r_busy, w_busy_d;
    logic              r_solved, w_solved_d;
    logic              r_err, w_err_d;

    logic              w_ready;
    logic              w_accept;
    logic [15:0]       w_lfsr_next;
    logic [RW-1:0]     w_row;
    logic [CW-1:0]     w_col;
    logic              w_valid;
    logic [N-1:0]      w_mask;

    assign w_ready     = lo.ena & (r_state != StScramble);
    assign w_accept    = lo.cmd_valid & w_ready;
    assign w_lfsr_next = lfsr_step(r_lfsr);

    // One mask generator serves both paths: scramble coordinates come from the stepped LFSR.
    assign w_row = (r_state == StScramble) ? w_lfsr_next[RW-1:0]     : lo.cmd_row;
    assign w_col = (r_state == StScramble) ? w_lfsr_next[RW+CW-1:RW] : lo.cmd_col;

    lightsout_press_mask #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .TORUS (TORUS)
    ) u_mask (
        .i_row   (w_row),
        .i_col   (w_col),
        .o_valid (w_valid),
        .o_mask  (w_mask)
    );

    always_comb begin
        w_state_d   = r_state;
        w_board_d   = r_board;
        w_moves_d   = r_moves;
        w_lfsr_d    = r_lfsr;
        w_scr_cnt_d = r_scr_cnt;
        w_err_d     = 1'b0;
        unique case (r_state)
            StIdle, StWon: begin
                if (w_accept) begin
                    unique case (cmd_op_e'(lo.cmd_op))
                        OP_PRESS: begin
                            if (r_state == StIdle) begin
                                if (w_valid) begin
                                    w_board_d = r_board ^ w_mask;
                                    if (r_moves != '1) w_moves_d = r_moves + MOVE_W'(1);
                                    if (w_board_d == '0) w_state_d = StWon;
                                end else begin
                                    w_err_d = 1'b1;
                                end
                            end
                        end
                        OP_SCRAMBLE: begin
                            w_lfsr_d    = (lo.seed == 16'h0000) ? LFSR_RESET : lo.seed;
                            w_board_d   = '0;
                            w_moves_d   = '0;
                            w_scr_cnt_d = '0;
                            w_state_d   = StScramble;
                        end
                        OP_CLEAR: begin
                            w_board_d = '0;
                            w_moves_d = '0;
                            w_state_d = StIdle;
                        end
                        OP_RESERVED: ;
                    endcase
                end
            end
            StScramble: begin
                w_lfsr_d = w_lfsr_next;
                if (w_valid) begin
                    w_board_d = r_board ^ w_mask;
                    // Quota reached: leave only on a lit board, else keep pressing.
                    if (int'(r_scr_cnt) + 1 >= SCRAMBLE) begin
                        if (w_board_d != '0) w_state_d = StIdle;
                    end else begin
                        w_scr_cnt_d = r_scr_cnt + SW'(1);
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
        w_busy_d   = (w_state_d == StScramble);
        w_solved_d = (w_state_d == StWon);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_board   <= '0;
            r_moves   <= '0;
            r_lfsr    <= LFSR_RESET;
            r_scr_cnt <= '0;
            r_busy    <= 1'b0;
            r_solved  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_board   <= w_board_d;
            r_moves   <= w_moves_d;
            r_lfsr    <= w_lfsr_d;
            r_scr_cnt <= w_scr_cnt_d;
            r_busy    <= w_busy_d;
            r_solved  <= w_solved_d;
            r_err     <= w_err_d;
        end
    end

    assign lo.cmd_ready  = w_ready;
    assign lo.board      = r_board;
    assign lo.move_count = r_moves;
    assign lo.busy       = r_busy;
    assign lo.solved     = r_solved;
    assign lo.err        = r_err;

endmodule
